disp_src_scheduler: RTL and testbench

//  Time-shares the 4-digit seven-segment display among NUM_SRC requesters (e.g. PC, ALU result, regfile read).

---
 rtl/disp_src_scheduler_pkg.sv | 30 +++
 rtl/disp_src_scheduler_if.sv | 31 +++
 rtl/disp_src_scheduler_bin2bcd.sv | 59 +++++
 rtl/disp_src_scheduler.sv | 130 +++++++++++++
 tb/tb_disp_src_scheduler.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/disp_src_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : disp_sched_pkg                                                  |
// | Purpose  : Shared types, sizes and leading-zero blank helper for the       |
// |            display source scheduler.                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package disp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 16;

    // Units digit is never blanked so a zero value still shows one '0'.
    function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd);
        logic [NUM_DIGITS-1:0] m;
        m    = '0;
        m[3] = (bcd[15:12] == 4'd0);
        m[2] = m[3] && (bcd[11:8] == 4'd0);
        m[1] = m[2] && (bcd[7:4] == 4'd0);
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_src_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : disp_src_scheduler_if                                           |
// | Purpose  : Requester/display bundle between the sources, the scheduler     |
// |            and the scanning display driver.                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface disp_src_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int VAL_W   = 13
);
    logic [NUM_SRC-1:0]       req;
    logic [NUM_SRC*VAL_W-1:0] value;
    logic [NUM_SRC-1:0]       grant;
    logic [2:0]               active_src;
    logic [15:0]              bcd_digits;
    logic                     bcd_valid;
    logic                     busy;
    logic [3:0]               blank;

    modport master (
        output req, value,
        input  grant, active_src, bcd_digits, bcd_valid, busy, blank
    );

    modport slave (
        input  req, value,
        output grant, active_src, bcd_digits, bcd_valid, busy, blank
    );
endinterface
`default_nettype wire

// File: rtl/disp_src_scheduler_bin2bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bin2bcd_seq                                                     |
// | Purpose  : Sequential shift-add-3 binary to packed BCD, one bit per cycle, |
// |            MSB first; loads on i_start, then VAL_W shift cycles.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bin2bcd_seq
    import disp_sched_pkg::*;
#(
    parameter int VAL_W = 13
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_start,
    input  wire logic [VAL_W-1:0] i_value,
    output logic                  o_done,
    output logic [BCD_W-1:0]      o_bcd
);
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] r_shift;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic [BCD_W-1:0] w_adj;
    logic [BCD_W-1:0] w_step;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_step = (w_adj << 1) | BCD_W'(r_shift[VAL_W-1]);
    end

    // o_bcd is the result of the step taken on the edge where o_done is high,
    // so the consumer captures the final value on that same edge.
    assign o_done = (r_cnt == CNT_W'(1));
    assign o_bcd  = w_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_shift <= i_value;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(VAL_W);
        end else if (r_cnt != '0) begin
            r_shift <= r_shift << 1;
            r_bcd   <= w_step;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/disp_src_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : disp_src_scheduler                                              |
// | Purpose  : Round-robin time-sharing of the 4-digit display among NUM_SRC   |
// |            requesters with sequential BCD conversion and dwell hold.       |
// |            Optional leading-zero blanking via `DISP_LZ_BLANK_EN.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module disp_src_scheduler
    import disp_sched_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int VAL_W        = 13,
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  wire logic             clk,
    input  wire logic             rst,
    disp_src_scheduler_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int DW_W  = $clog2(DWELL_CYCLES + 1);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_last;
    logic [VAL_W-1:0]       r_latched;
    logic [NUM_SRC-1:0]     r_grant;
    logic [2:0]             r_active;
    logic [BCD_W-1:0]       r_bcd;
    logic                   r_valid;
    logic                   r_busy;
    logic [NUM_DIGITS-1:0]  r_blank;
    logic [DW_W-1:0]        r_dwell;

    logic                   w_found;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_done;
    logic [BCD_W-1:0]       w_bcd;
    logic [NUM_DIGITS-1:0]  w_blank_next;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int w_idx;
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= NUM_SRC) begin
                w_idx = w_idx - NUM_SRC;
            end
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(w_idx);
            end
        end
    end

`ifdef DISP_LZ_BLANK_EN
    assign w_blank_next = blank_mask(w_bcd);
`else
    assign w_blank_next = '0;
`endif

    // The grant pulse doubles as the converter load strobe.
    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (|r_grant),
        .i_value (r_latched),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= IDX_W'(NUM_SRC - 1);
            r_latched <= '0;
            r_grant   <= '0;
            r_active  <= '0;
            r_bcd     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_blank   <= '0;
            r_dwell   <= '0;
        end else begin
            r_grant <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_latched       <= bus.value[int'(w_pick)*VAL_W +: VAL_W];
                        r_grant[w_pick] <= 1'b1;
                        r_last          <= w_pick;
                        r_busy          <= 1'b1;
                        r_state         <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (w_done) begin
                        r_bcd    <= w_bcd;
                        r_active <= 3'(r_last);
                        r_blank  <= w_blank_next;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_dwell  <= DW_W'(DWELL_CYCLES - 1);
                        r_state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_dwell == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_dwell <= r_dwell - DW_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.active_src = r_active;
    assign bus.bcd_digits = r_bcd;
    assign bus.bcd_valid  = r_valid;
    assign bus.busy       = r_busy;
    assign bus.blank      = r_blank;
endmodule
`default_nettype wire

// File: tb/tb_disp_src_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_disp_src_scheduler                                           |
// | Purpose  : Directed, table-driven bench for disp_src_scheduler             |
// |            (blank expectations follow `DISP_LZ_BLANK_EN).                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_disp_src_scheduler;
    localparam int NUM_SRC = 4;
    localparam int VAL_W   = 13;
    localparam int DWELL   = 4;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    disp_src_scheduler_if #(.NUM_SRC(NUM_SRC), .VAL_W(VAL_W)) bus ();

    disp_src_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .VAL_W        (VAL_W),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [12:0] v0, v1, v2, v3;
        logic [3:0]  grant;
        logic [2:0]  src;
        logic [15:0] bcd;
        logic [3:0]  blank;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [3:0] exp_blank(input logic [3:0] lz);
`ifdef DISP_LZ_BLANK_EN
        return lz;
`else
        return (lz & 4'b0000);
`endif
    endfunction

    task automatic set_vals(input logic [12:0] a, b, c, d);
        bus.value = {d, c, b, a};
    endtask

    // Called right after inputs were driven on a negedge; returns at the
    // negedge where the converted value must first be visible.
    task automatic run_conv(input string tag, input logic [3:0] eg, input logic [2:0] es,
                            input logic [15:0] eb, input logic [3:0] ebl,
                            input bit drop, input bit poke);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (|bus.grant) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_total++;
            $display("FAIL %s_grant_timeout: got none, expected %0h", tag, eg);
            return;
        end
        check({tag, "_grant"}, 32'(bus.grant), 32'(eg));
        if (drop) bus.req = 4'b0000;
        if (poke) bus.value[12:0] = 13'd99;
        repeat (13) @(negedge clk);
        check({tag, "_busy_before_done"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        check({tag, "_bcd"},    32'(bus.bcd_digits), 32'(eb));
        check({tag, "_src"},    32'(bus.active_src), 32'(es));
        check({tag, "_blank"},  32'(bus.blank),      32'(exp_blank(ebl)));
        check({tag, "_valid"},  32'(bus.bcd_valid),  32'd1);
        check({tag, "_busy"},   32'(bus.busy),       32'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        bus.req = 4'b1111;
        set_vals(13'd1234, 13'd111, 13'd222, 13'd333);

        tbl[0] = '{4'b0001, 13'd1234, 13'd111, 13'd222, 13'd333,  4'b0001, 3'd0, 16'h1234, 4'b0000};
        tbl[1] = '{4'b0010, 13'd111,  13'd42,  13'd222, 13'd333,  4'b0010, 3'd1, 16'h0042, 4'b1100};
        tbl[2] = '{4'b1000, 13'd111,  13'd222, 13'd333, 13'd8191, 4'b1000, 3'd3, 16'h8191, 4'b0000};
        tbl[3] = '{4'b0100, 13'd111,  13'd222, 13'd0,   13'd333,  4'b0100, 3'd2, 16'h0000, 4'b1110};
        tbl[4] = '{4'b0001, 13'd7,    13'd111, 13'd222, 13'd333,  4'b0001, 3'd0, 16'h0007, 4'b1110};
        tbl[5] = '{4'b1100, 13'd111,  13'd222, 13'd905, 13'd333,  4'b0100, 3'd2, 16'h0905, 4'b1000};
        tbl[6] = '{4'b1001, 13'd111,  13'd222, 13'd333, 13'd10,   4'b1000, 3'd3, 16'h0010, 4'b1100};
        tbl[7] = '{4'b1001, 13'd5000, 13'd111, 13'd222, 13'd333,  4'b0001, 3'd0, 16'h5000, 4'b0000};

        // Reset held three cycles with every source requesting.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_grant", 32'(bus.grant), 32'd0);
        end
        check("rst_bcd",    32'(bus.bcd_digits), 32'd0);
        check("rst_valid",  32'(bus.bcd_valid),  32'd0);
        check("rst_busy",   32'(bus.busy),       32'd0);
        check("rst_blank",  32'(bus.blank),      32'd0);
        check("rst_active", 32'(bus.active_src), 32'd0);
        rst = 1'b0;
        run_conv("first", 4'b0001, 3'd0, 16'h1234, 4'b0000, 1'b1, 1'b0);
        repeat (6) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            bus.req = tbl[i].req;
            set_vals(tbl[i].v0, tbl[i].v1, tbl[i].v2, tbl[i].v3);
            run_conv($sformatf("vec%0d", i), tbl[i].grant, tbl[i].src, tbl[i].bcd, tbl[i].blank,
                     1'b1, 1'b0);
            repeat (6) @(negedge clk);
        end

        // Reset in the middle of a conversion discards it.
        bus.req = 4'b0001;
        set_vals(13'd1234, 13'd111, 13'd222, 13'd333);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (|bus.grant) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) begin
                n_total++;
                $display("FAIL abort_grant_timeout: got none, expected 1");
            end
        end
        bus.req = 4'b0000;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(bus.bcd_valid),  32'd0);
        check("abort_bcd",   32'(bus.bcd_digits), 32'd0);
        check("abort_busy",  32'(bus.busy),       32'd0);
        begin
            int n_grants;
            n_grants = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (|bus.grant) n_grants++;
            end
            check("abort_idle_no_grant", 32'(n_grants), 32'd0);
            check("abort_stays_blank", 32'(bus.bcd_digits), 32'd0);
        end

        // Two persistent requesters alternate, starting from source 0 after reset.
        bus.req = 4'b0101;
        set_vals(13'd7, 13'd111, 13'd8191, 13'd333);
        run_conv("alt0", 4'b0001, 3'd0, 16'h0007, 4'b1110, 1'b0, 1'b0);
        run_conv("alt1", 4'b0100, 3'd2, 16'h8191, 4'b0000, 1'b0, 1'b0);
        run_conv("alt2", 4'b0001, 3'd0, 16'h0007, 4'b1110, 1'b0, 1'b0);
        run_conv("alt3", 4'b0100, 3'd2, 16'h8191, 4'b0000, 1'b1, 1'b0);
        repeat (6) @(negedge clk);

        // Request dropped and value changed right after the grant.
        bus.req = 4'b0001;
        set_vals(13'd1234, 13'd111, 13'd222, 13'd333);
        run_conv("drop", 4'b0001, 3'd0, 16'h1234, 4'b0000, 1'b1, 1'b1);
        begin
            int n_grants;
            n_grants = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (|bus.grant) n_grants++;
            end
            check("drop_no_regrant", 32'(n_grants), 32'd0);
            check("drop_still_1234", 32'(bus.bcd_digits), 32'h1234);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
